// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the two-requester SRAM port arbiter: FSM states,
// requester count and the request bundle carried through the mux.
package sram_port_arbiter_pkg;

  localparam int NUM_REQ         = 2;
  localparam int SRAM_ADDR_WIDTH = 8;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    INIT = ST_INIT,
    RUN  = ST_RUN
  } state_e;

  // Field widths follow the package defaults; the top's parameters track them.
  typedef struct packed {
    logic                       we;
    logic [SRAM_NUM_WMASKS-1:0] be;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } req_t;

  function automatic logic [SRAM_NUM_WMASKS-1:0] lane_mask(input req_t r);
    return r.we ? r.be : '1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter: two request/response
// channels; master is the requester side, slave is the arbiter side.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS
);

  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0]                 we_i;
  logic [NUM_REQ-1:0][NUM_WMASKS-1:0] be_i;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]                 gnt_o;
  logic [NUM_REQ-1:0]                 rvalid_o;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way grant logic for the shared SRAM port. Define SRAM_ARB_ROUND_ROBIN_EN
// for round-robin on ties; otherwise requester 0 always wins.
module sram_rr_arbiter
  import sram_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic ptr;  // requester that wins the next tie

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr <= 1'b0;
    else if (|gnt)  ptr <= gnt[0];
  end

  // NOTE: outputs get a default first so no path through the block infers a latch.
  always_comb begin
    gnt = '0;
    if (en) begin
      if (&req) gnt[ptr] = 1'b1;
      else      gnt      = req;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt = '0;
    if (en) gnt = req[0] ? 2'b01 : req;
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM RW port between two requesters: zeroes the array after
// reset, then arbitrates (see SRAM_ARB_ROUND_ROBIN_EN) with 1-cycle reads.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_port_arbiter_if.slave    bus,
  output logic                  init_done_o,
  output logic                  csb0_o,
  output logic                  web0_o,
  output logic [NUM_WMASKS-1:0] wmask0_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0] din0_o,
  input  logic [DATA_WIDTH-1:0] dout0_i
);

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = 1;

  state_e              state;
  logic [ADDR_WIDTH:0] init_cnt;
  logic [NUM_REQ-1:0]  gnt;
  logic [NUM_REQ-1:0]  rvalid_q;
  req_t                reqs [NUM_REQ];
  req_t                sel;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign reqs[r] = '{we: bus.we_i[r], be: bus.be_i[r],
                       addr: bus.addr_i[r], wdata: bus.wdata_i[r]};
    assign bus.rdata_o[r] = rvalid_q[r] ? dout0_i : '0;
  end

  sram_rr_arbiter u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .en  (state == RUN),
    .req (bus.req_i),
    .gnt (gnt)
  );

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign sel          = gnt[1] ? reqs[1] : reqs[0];
  assign init_done_o  = (state == RUN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + CNT_ONE;
      if (init_cnt == LAST_ADDR) state <= RUN;
    end
  end

  // Read data appears on dout0_i the cycle after the access is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rvalid_q <= '0;
    else       rvalid_q <= gnt & bus.req_i & ~bus.we_i;
  end

  always_comb begin
    csb0_o   = 1'b1;
    web0_o   = 1'b1;
    wmask0_o = '0;
    addr0_o  = '0;
    din0_o   = '0;
    if (!rst_i) begin
      if (state == INIT) begin
        csb0_o   = 1'b0;
        web0_o   = 1'b0;
        wmask0_o = '1;
        addr0_o  = init_cnt[ADDR_WIDTH-1:0];
      end else if (|gnt) begin
        csb0_o   = 1'b0;
        web0_o   = ~sel.we;
        wmask0_o = lane_mask(sel);
        addr0_o  = sel.addr;
        din0_o   = sel.wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM that latches
// on the rising edge and writes/reads on the falling edge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done, csb0, web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0, dout0;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  sram_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4)) bus ();

  sram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .init_done_o (init_done),
    .csb0_o      (csb0),
    .web0_o      (web0),
    .wmask0_o    (wmask0),
    .addr0_o     (addr0),
    .din0_o      (din0),
    .dout0_i     (dout0)
  );

  always #5 clk = ~clk;

  // SRAM model
  logic [31:0] mem [256];
  logic        lat_en, lat_we;
  logic [7:0]  lat_addr;
  logic [31:0] lat_din;
  logic [3:0]  lat_mask;

  always @(posedge clk) begin
    lat_en   <= !csb0;
    lat_we   <= !web0;
    lat_addr <= addr0;
    lat_din  <= din0;
    lat_mask <= wmask0;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5A5A5;
    forever begin
      @(negedge clk);
      if (lat_en) begin
        if (lat_we) begin
          for (int b = 0; b < 4; b++)
            if (lat_mask[b]) mem[lat_addr][8*b +: 8] = lat_din[8*b +: 8];
        end else begin
          dout0 = mem[lat_addr];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
  endtask

  task automatic drive(input int r, input logic we, input logic [3:0] be,
                       input logic [7:0] addr, input logic [31:0] wdata);
    bus.req_i[r]   = 1'b1;
    bus.we_i[r]    = we;
    bus.be_i[r]    = be;
    bus.addr_i[r]  = addr;
    bus.wdata_i[r] = wdata;
  endtask

  // Expected rdata bus for the contention phase: lane0 reads 0x10, lane1 reads 0x20.
  function automatic logic [63:0] exp_rd(input logic [1:0] g);
    return {g[1] ? 32'h12345678 : 32'h0, g[0] ? 32'h0000BEEF : 32'h0};
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_gnt [4];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b0, 4'hF, 8'h00, 32'h0);
    drive(1, 1'b0, 4'hF, 8'h00, 32'h0);
    #1;
    check("rst_csb0", csb0, 1'b1);
    check("rst_gnt", bus.gnt_o, 2'b00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_rvalid", bus.rvalid_o, 2'b00);
    check("rst_rdata", bus.rdata_o, 64'h0);

    // Zeroing sweep; requests held high must stay ungranted.
    mid();
    rst = 1'b0;
    #1;
    check("init_csb0", csb0, 1'b0);
    check("init_web0", web0, 1'b0);
    check("init_wmask", wmask0, 4'hF);
    check("init_addr0", addr0, 8'h00);
    check("init_din0", din0, 32'h0);
    check("init_gnt", bus.gnt_o, 2'b00);
    repeat (100) @(posedge clk);
    #1;
    check("init_addr_100", addr0, 8'd100);
    check("init_gnt_100", bus.gnt_o, 2'b00);
    idle();
    repeat (155) @(posedge clk);
    #1;
    check("init_done_255", init_done, 1'b0);
    check("init_addr_255", addr0, 8'hFF);
    after_pos();
    check("init_done_256", init_done, 1'b1);
    check("run_idle_csb0", csb0, 1'b1);

    // Read top address after zeroing.
    drive(0, 1'b0, 4'hF, 8'hFF, 32'h0);
    #1;
    check("rd_ff_gnt", bus.gnt_o, 2'b01);
    check("rd_ff_web0", web0, 1'b1);
    check("rd_ff_addr0", addr0, 8'hFF);
    after_pos();
    idle();
    check("rd_ff_rvalid", bus.rvalid_o, 2'b01);
    mid();
    check("rd_ff_rdata", bus.rdata_o, 64'h0);
    after_pos();
    check("rd_ff_rvalid_drop", bus.rvalid_o, 2'b00);

    // Requester 0 partial write, then read back.
    drive(0, 1'b1, 4'b0011, 8'h10, 32'hDEADBEEF);
    #1;
    check("wr10_gnt", bus.gnt_o, 2'b01);
    check("wr10_web0", web0, 1'b0);
    check("wr10_wmask", wmask0, 4'b0011);
    check("wr10_din0", din0, 32'hDEADBEEF);
    after_pos();
    drive(0, 1'b0, 4'b0000, 8'h10, 32'h0);
    #1;
    check("wr10_no_rvalid", bus.rvalid_o, 2'b00);
    check("rd10_wmask_ones", wmask0, 4'hF);
    after_pos();
    idle();
    mid();
    check("rd10_rvalid", bus.rvalid_o, 2'b01);
    check("rd10_rdata", bus.rdata_o, {32'h0, 32'h0000BEEF});
    after_pos();

    // Requester 1 write then immediate read of the same address.
    drive(1, 1'b1, 4'hF, 8'h20, 32'h12345678);
    #1;
    check("wr20_gnt", bus.gnt_o, 2'b10);
    check("wr20_din0", din0, 32'h12345678);
    after_pos();
    drive(1, 1'b0, 4'hF, 8'h20, 32'h0);
    #1;
    check("rd20_gnt", bus.gnt_o, 2'b10);
    after_pos();
    idle();
    mid();
    check("rd20_rvalid", bus.rvalid_o, 2'b10);
    check("rd20_rdata", bus.rdata_o, {32'h12345678, 32'h0});
    after_pos();

    // Both requesters read continuously for four cycles.
    drive(0, 1'b0, 4'hF, 8'h10, 32'h0);
    drive(1, 1'b0, 4'hF, 8'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_gnt_%0d", i), bus.gnt_o, exp_gnt[i]);
      mid();
      if (i > 0) begin
        check($sformatf("cont_rvalid_%0d", i), bus.rvalid_o, exp_gnt[i-1]);
        check($sformatf("cont_rdata_%0d", i), bus.rdata_o, exp_rd(exp_gnt[i-1]));
      end
      after_pos();
    end
    idle();
    mid();
    check("cont_rvalid_last", bus.rvalid_o, exp_gnt[3]);
    check("cont_rdata_last", bus.rdata_o, exp_rd(exp_gnt[3]));
    after_pos();

    // Reset in the middle of a granted read.
    drive(0, 1'b0, 4'hF, 8'h10, 32'h0);
    #1;
    check("rstrd_gnt", bus.gnt_o, 2'b01);
    #1;
    rst = 1'b1;
    #1;
    check("rstrd_gnt_drop", bus.gnt_o, 2'b00);
    check("rstrd_csb0", csb0, 1'b1);
    idle();
    after_pos();
    check("rstrd_no_rvalid", bus.rvalid_o, 2'b00);
    check("rstrd_rdata", bus.rdata_o, 64'h0);
    check("rstrd_init_done", init_done, 1'b0);
    mid();
    rst = 1'b0;
    #1;
    check("reinit_addr0", addr0, 8'h00);
    check("reinit_csb0", csb0, 1'b0);
    check("reinit_web0", web0, 1'b0);
    after_pos();
    check("reinit_addr1", addr0, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-lane count (DATA_WIDTH/8).
REQ-004 SHALL have port clk_i, input, 1, single clock; it also clocks the SRAM clk0.
REQ-005 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have ports req_i[r], we_i[r], be_i[r] (NUM_WMASKS), addr_i[r] (ADDR_WIDTH) and wdata_i[r] (DATA_WIDTH), all inputs, for requesters r = 0 and 1.
REQ-007 SHALL have ports gnt_o[r], rvalid_o[r] (1 bit each) and rdata_o[r] (DATA_WIDTH), all outputs, for r = 0 and 1.
REQ-008 SHALL have port init_done_o, output, 1, high once memory zeroing is complete.
REQ-009 SHALL have ports csb0_o, web0_o, wmask0_o, addr0_o and din0_o, outputs, driving the SRAM RW port; csb0_o and web0_o are active-low.
REQ-010 SHALL have port dout0_i, input, DATA_WIDTH, SRAM read data.

Function
REQ-011 SHALL implement FSM states INIT and RUN only.
REQ-012 In INIT, SHALL write zero with wmask0_o all-ones to each address from 0 to 2^ADDR_WIDTH-1, one address per cycle, using a counter of ADDR_WIDTH+1 bits.
REQ-013 After the last address is written, SHALL enter RUN on the next edge, set init_done_o=1, and never re-enter INIT except through reset.
REQ-014 SHALL hold gnt_o low for both requesters while in INIT, whatever req_i is.
REQ-015 In RUN, SHALL assert at most one gnt_o per cycle, combinationally in the same cycle as the matching req_i.
REQ-016 A request SHALL be accepted when req_i and gnt_o are both high at a rising clk_i edge.
REQ-017 While a requester holds req_i without a grant, it SHALL keep its other request inputs stable.
REQ-018 On grant, SHALL drive csb0_o=0, web0_o=!we_i, wmask0_o=be_i (all-ones for reads), and addr0_o/din0_o from the granted requester.
REQ-019 With no grant, SHALL drive csb0_o=1, web0_o=1, and all other SRAM outputs to 0.
REQ-020 On an accepted read, SHALL pulse rvalid_o of that requester high for exactly the following cycle, with rdata_o=dout0_i during that cycle; latency is 1 cycle.
REQ-021 Writes SHALL produce no rvalid_o.
REQ-022 rdata_o SHALL equal 0 whenever rvalid_o is low.
REQ-023 Back-to-back accepted requests SHALL be allowed every cycle (full throughput).
REQ-024 A read to an address written in the previous cycle SHALL return the new data; the SRAM gives this because it writes on the falling edge of the write cycle.

Reset
REQ-025 Asserting rst_i SHALL immediately force state=INIT, counter=0, init_done_o=0, and the RR pointer to requester 0.
REQ-026 Asserting rst_i SHALL immediately clear all rvalid_o, gnt_o and rdata_o, and set csb0_o=1.
REQ-027 Reset arriving mid-INIT or mid-read SHALL drop the operation; zeroing restarts from address 0 after release.

Configuration
REQ-028 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the requester not granted most recently; a 1-bit pointer updates only on an accepted request.
REQ-029 Macro SRAM_ARB_ROUND_ROBIN_EN undefined: requester 0 SHALL always win; no pointer exists.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (INIT, RUN), the requester-count constant (2), and the request struct (we, be, addr, wdata).
REQ-031 Arbitration SHALL live in one sub-module, sram_rr_arbiter (2-way; fixed or round-robin per the macro); the FSM and response routing stay in the top.

Verification
REQ-032 Release reset with ADDR_WIDTH=8: init_done_o rises exactly 256 cycles later; a subsequent read of address 0xFF returns 0.
REQ-033 Requester 0 writes 0xDEADBEEF to address 0x10 with be=4'b0011, then reads it back: rdata_o[0]=0x0000BEEF with rvalid_o[0] one cycle after the read grant.
REQ-034 Both requesters read continuously for 4 cycles: with the macro, grants alternate 0,1,0,1; without it, requester 0 gets all four grants and gnt_o[1] stays low.
REQ-035 Requester 1 writes 0x12345678 to address 0x20 in cycle N and reads 0x20 in cycle N+1: rdata_o[1]=0x12345678 in cycle N+2.
REQ-036 Assert rst_i during the cycle in which a read is granted: rvalid_o stays 0, csb0_o=1 immediately, and INIT restarts at address 0.
